// File: rtl/bus_arbiter_if.sv
// Request/bus signal bundle for bus_arbiter: N requesting masters on one side,
// a single shared bus on the other. The arbiter uses the slave view; the
// environment (requesters plus bus responder) uses the master view.
interface bus_arbiter_if #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned XLEN    = 32
);
    localparam int unsigned BE_W = XLEN / 8;

    // requester side
    logic [N_PORTS-1:0]      i_req;
    logic [N_PORTS-1:0]      i_wen;
    logic [N_PORTS*XLEN-1:0] i_addr;
    logic [N_PORTS*XLEN-1:0] i_wdata;
    logic [N_PORTS*BE_W-1:0] i_byte_en;
    logic [N_PORTS-1:0]      o_ready;
    logic [XLEN-1:0]         o_rdata;
    logic                    o_err;

    // bus side
    logic                    o_bus_en;
    logic                    o_wr_en;
    logic [XLEN-1:0]         o_addr;
    logic [XLEN-1:0]         o_wr_data;
    logic [BE_W-1:0]         o_byte_en;
    logic                    i_ack;
    logic [XLEN-1:0]         i_rd_data;

    modport slave (
        input  i_req, i_wen, i_addr, i_wdata, i_byte_en, i_ack, i_rd_data,
        output o_ready, o_rdata, o_err,
        output o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
    );

    modport master (
        output i_req, i_wen, i_addr, i_wdata, i_byte_en, i_ack, i_rd_data,
        input  o_ready, o_rdata, o_err,
        input  o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting one of N_PORTS masters access to a single bus.
// IDLE picks a port and latches its request, BUSY drives the bus until ack or
// timeout, DONE pulses o_ready for the granted port for one cycle.
// All outputs are registered and computed from the next state.
module bus_arbiter #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    bus_arbiter_if.slave  bus
);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned GNT_W = $clog2(N_PORTS);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [GNT_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_PORTS-1:0]   ready_q, ready_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 bus_en_q, bus_en_d;
    logic                 wr_en_q, wr_en_d;
    logic [XLEN-1:0]      addr_q, addr_d;
    logic [XLEN-1:0]      wr_data_q, wr_data_d;
    logic [BE_W-1:0]      byte_en_q, byte_en_d;

    logic [XLEN-1:0]      port_addr    [N_PORTS];
    logic [XLEN-1:0]      port_wdata   [N_PORTS];
    logic [BE_W-1:0]      port_byte_en [N_PORTS];

    logic                 pick_valid;
    logic [GNT_W-1:0]     pick_idx;
    logic [GNT_W-1:0]     cand;
    logic                 timeout_hit;

    // Unpack the flat per-port request fields into arrays indexed by port.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
        assign port_addr[p]    = bus.i_addr[p*XLEN +: XLEN];
        assign port_wdata[p]   = bus.i_wdata[p*XLEN +: XLEN];
        assign port_byte_en[p] = bus.i_byte_en[p*BE_W +: BE_W];
    end

    // Round-robin pick: first requesting port after the last grant, wrapping.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            cand = GNT_W'((32'(last_grant_q) + i) % N_PORTS);
            if (!pick_valid && bus.i_req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The wait counter reaches TIMEOUT on this cycle if it is not acked now.
    assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

    // Next-state and next-output logic; bus fields are zero unless in BUSY.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ready_d      = '0;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        bus_en_d     = 1'b0;
        wr_en_d      = 1'b0;
        addr_d       = '0;
        wr_data_d    = '0;
        byte_en_d    = '0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d      = BUSY;
                    last_grant_d = pick_idx;
                    cnt_d        = '0;
                    bus_en_d     = 1'b1;
                    wr_en_d      = bus.i_wen[pick_idx];
                    addr_d       = port_addr[pick_idx];
                    wr_data_d    = port_wdata[pick_idx];
                    byte_en_d    = port_byte_en[pick_idx];
                end
            end
            BUSY: begin
                if (bus.i_ack) begin
                    // ack wins over a simultaneous timeout
                    state_d               = DONE;
                    rdata_d               = bus.i_rd_data;
                    err_d                 = 1'b0;
                    ready_d[last_grant_q] = 1'b1;
                end else if (timeout_hit) begin
                    state_d               = DONE;
                    rdata_d               = '0;
                    err_d                 = 1'b1;
                    ready_d[last_grant_q] = 1'b1;
                end else begin
                    bus_en_d  = 1'b1;
                    wr_en_d   = wr_en_q;
                    addr_d    = addr_q;
                    wr_data_d = wr_data_q;
                    byte_en_d = byte_en_q;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_W'(N_PORTS - 1);
            cnt_q        <= '0;
            ready_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            bus_en_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            byte_en_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            bus_en_q     <= bus_en_d;
            wr_en_q      <= wr_en_d;
            addr_q       <= addr_d;
            wr_data_q    <= wr_data_d;
            byte_en_q    <= byte_en_d;
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_rdata   = rdata_q;
    assign bus.o_err     = err_q;
    assign bus.o_bus_en  = bus_en_q;
    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign bus.o_byte_en = byte_en_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a per-cycle vector table for arbitration
// and read handshakes, plus hand-written write, timeout and reset sequences.
// dut_a uses TIMEOUT=4, dut_b uses TIMEOUT=0 (no abort).
module tb_bus_arbiter;

    logic clk;
    logic rst_n;

    bus_arbiter_if #(.N_PORTS(2), .XLEN(32)) ifa ();
    bus_arbiter_if #(.N_PORTS(2), .XLEN(32)) ifb ();

    bus_arbiter #(.N_PORTS(2), .XLEN(32), .TIMEOUT(4)) dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifa)
    );

    bus_arbiter #(.N_PORTS(2), .XLEN(32), .TIMEOUT(0)) dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  req;
        logic        ack;
        logic [31:0] rd_data;
        logic        exp_bus_en;
        logic [1:0]  exp_ready;
        logic [31:0] exp_addr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    localparam logic [31:0] A0 = 32'h0000_0100;
    localparam logic [31:0] A1 = 32'h0000_0200;

    task automatic add(input logic [1:0] req, input logic ack, input logic [31:0] rd,
                       input logic eb, input logic [1:0] er, input logic [31:0] ea,
                       input logic [31:0] erd);
        vec_t v;
        v.req        = req;
        v.ack        = ack;
        v.rd_data    = rd;
        v.exp_bus_en = eb;
        v.exp_ready  = er;
        v.exp_addr   = ea;
        v.exp_rdata  = erd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // {bus_en, wr_en, ready, err, addr}
    function automatic logic [36:0] snap_a();
        return {ifa.o_bus_en, ifa.o_wr_en, ifa.o_ready, ifa.o_err, ifa.o_addr};
    endfunction

    function automatic logic [36:0] snap_b();
        return {ifb.o_bus_en, ifb.o_wr_en, ifb.o_ready, ifb.o_err, ifb.o_addr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ifa.i_req = '0; ifa.i_wen = '0; ifa.i_ack = 1'b0; ifa.i_rd_data = '0;
        ifa.i_addr    = {A1, A0};
        ifa.i_wdata   = {32'h1234_5678, 32'hA5A5_A5A5};
        ifa.i_byte_en = {4'b0011, 4'b1111};
        ifb.i_req = '0; ifb.i_wen = '0; ifb.i_ack = 1'b0; ifb.i_rd_data = '0;
        ifb.i_addr    = {A1, A0};
        ifb.i_wdata   = '0;
        ifb.i_byte_en = '0;

        // single read, then alternating grants, then ack while idle
        add(2'b01, 1'b0, 32'h0,         1'b1, 2'b00, A0,    32'h0);
        add(2'b01, 1'b0, 32'h0,         1'b1, 2'b00, A0,    32'h0);
        add(2'b01, 1'b0, 32'h0,         1'b1, 2'b00, A0,    32'h0);
        add(2'b01, 1'b1, 32'hDEADBEEF,  1'b0, 2'b01, 32'h0, 32'hDEADBEEF);
        add(2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0, 32'h0);
        add(2'b11, 1'b0, 32'h0,         1'b1, 2'b00, A1,    32'h0);
        add(2'b11, 1'b1, 32'h1111_1111, 1'b0, 2'b10, 32'h0, 32'h1111_1111);
        add(2'b11, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0, 32'h0);
        add(2'b11, 1'b0, 32'h0,         1'b1, 2'b00, A0,    32'h0);
        add(2'b11, 1'b1, 32'h2222_2222, 1'b0, 2'b01, 32'h0, 32'h2222_2222);
        add(2'b11, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0, 32'h0);
        add(2'b11, 1'b0, 32'h0,         1'b1, 2'b00, A1,    32'h0);
        add(2'b11, 1'b1, 32'h3333_3333, 1'b0, 2'b10, 32'h0, 32'h3333_3333);
        add(2'b11, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0, 32'h0);
        add(2'b11, 1'b0, 32'h0,         1'b1, 2'b00, A0,    32'h0);
        add(2'b11, 1'b1, 32'h4444_4444, 1'b0, 2'b01, 32'h0, 32'h4444_4444);
        add(2'b00, 1'b1, 32'hAAAA_AAAA, 1'b0, 2'b00, 32'h0, 32'h0);
        add(2'b00, 1'b1, 32'hBBBB_BBBB, 1'b0, 2'b00, 32'h0, 32'h0);
        add(2'b00, 1'b1, 32'hCCCC_CCCC, 1'b0, 2'b00, 32'h0, 32'h0);
        add(2'b00, 1'b0, 32'h0,         1'b0, 2'b00, 32'h0, 32'h0);

        // reset state
        repeat (2) step();
        check("reset_a", 128'({snap_a(), ifa.o_wr_data, ifa.o_byte_en, ifa.o_rdata}), 128'h0);
        check("reset_b", 128'(snap_b()), 128'h0);
        rst_n = 1'b1;

        // table
        for (int i = 0; i < vecs.size(); i++) begin
            ifa.i_req     = vecs[i].req;
            ifa.i_ack     = vecs[i].ack;
            ifa.i_rd_data = vecs[i].rd_data;
            step();
            check($sformatf("row%0d_bus", i), 128'(snap_a()),
                  128'({vecs[i].exp_bus_en, 1'b0, vecs[i].exp_ready, 1'b0, vecs[i].exp_addr}));
            if (vecs[i].exp_ready != 2'b00)
                check($sformatf("row%0d_rdata", i), 128'(ifa.o_rdata), 128'(vecs[i].exp_rdata));
        end

        // write on port 1: fields stable through BUSY, zero in DONE and IDLE
        ifa.i_req = 2'b10; ifa.i_wen = 2'b10; ifa.i_ack = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            check($sformatf("wr_busy%0d", c), 128'({snap_a(), ifa.o_wr_data, ifa.o_byte_en}),
                  128'({1'b1, 1'b1, 2'b00, 1'b0, A1, 32'h1234_5678, 4'b0011}));
        end
        ifa.i_ack = 1'b1; ifa.i_rd_data = 32'hCAFE_F00D;
        step();
        check("wr_done", 128'({snap_a(), ifa.o_wr_data, ifa.o_byte_en, ifa.o_rdata}),
              128'({1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 4'b0000, 32'hCAFE_F00D}));
        ifa.i_req = 2'b00; ifa.i_wen = 2'b00; ifa.i_ack = 1'b0;
        step();
        check("wr_idle", 128'({snap_a(), ifa.o_wr_data, ifa.o_byte_en}), 128'h0);

        // timeout: four BUSY cycles, error completion, ack in DONE ignored
        ifa.i_req = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("to_busy%0d", c), 128'(snap_a()), 128'({1'b1, 1'b0, 2'b00, 1'b0, A0}));
        end
        step();
        check("to_done", 128'({snap_a(), ifa.o_rdata}), 128'({1'b0, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0}));
        ifa.i_req = 2'b00; ifa.i_ack = 1'b1; ifa.i_rd_data = 32'h5555_5555;
        step();
        check("to_idle", 128'(snap_a()), 128'h0);
        ifa.i_ack = 1'b0;
        // next request after a timeout completes normally
        ifa.i_req = 2'b01;
        step();
        check("post_to_busy", 128'(snap_a()), 128'({1'b1, 1'b0, 2'b00, 1'b0, A0}));
        ifa.i_ack = 1'b1; ifa.i_rd_data = 32'h0BAD_C0DE;
        step();
        check("post_to_done", 128'({snap_a(), ifa.o_rdata}),
              128'({1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0BAD_C0DE}));
        ifa.i_req = 2'b00; ifa.i_ack = 1'b0;
        step();

        // ack on the cycle the counter reaches TIMEOUT: ack wins
        ifa.i_req = 2'b01;
        repeat (4) step();
        check("race_busy4", 128'(snap_a()), 128'({1'b1, 1'b0, 2'b00, 1'b0, A0}));
        ifa.i_ack = 1'b1; ifa.i_rd_data = 32'h7777_7777;
        step();
        check("race_done", 128'({snap_a(), ifa.o_rdata}),
              128'({1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'h7777_7777}));
        ifa.i_req = 2'b00; ifa.i_ack = 1'b0;
        step();

        // reset in the middle of BUSY
        ifa.i_req = 2'b10;
        step();
        check("rst_pre", 128'(snap_a()), 128'({1'b1, 1'b0, 2'b00, 1'b0, A1}));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 128'({snap_a(), ifa.o_wr_data, ifa.o_byte_en, ifa.o_rdata}), 128'h0);
        ifa.i_req = 2'b11;
        ifa.i_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            check($sformatf("rst_hold%0d", c), 128'(snap_a()), 128'h0);
        end
        ifa.i_ack = 1'b0;
        rst_n = 1'b1;
        step();
        check("rst_first_grant", 128'(snap_a()), 128'({1'b1, 1'b0, 2'b00, 1'b0, A0}));
        ifa.i_ack = 1'b1; ifa.i_rd_data = 32'h6666_6666;
        step();
        check("rst_first_done", 128'(snap_a()), 128'({1'b0, 1'b0, 2'b01, 1'b0, 32'h0}));
        ifa.i_req = 2'b00; ifa.i_ack = 1'b0;
        step();

        // TIMEOUT=0: bus wait is unbounded
        ifb.i_req = 2'b01;
        for (int c = 1; c <= 10; c++) begin
            step();
            check($sformatf("nto_busy%0d", c), 128'(snap_b()), 128'({1'b1, 1'b0, 2'b00, 1'b0, A0}));
        end
        ifb.i_ack = 1'b1; ifb.i_rd_data = 32'hFEED_FACE;
        step();
        check("nto_done", 128'({snap_b(), ifb.o_rdata}),
              128'({1'b0, 1'b0, 2'b01, 1'b0, 32'h0, 32'hFEED_FACE}));
        ifb.i_req = 2'b00; ifb.i_ack = 1'b0;
        step();
        check("nto_idle", 128'(snap_b()), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
